shift_sched: RTL

- Shared-shifter scheduler: arbitrates two requesters (ALU path, memory-alignment path) onto a single instance of the 32-bit rotate-left `shifter`.
- Converts a rotate into SHL/SHR/SAR using a post-rotate mask and sign fill.
- Registers the result and holds it under valid/ready backpressure.
- Sits between the microcode sequencer's issue stage and the writeback mux.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_mask.sv | 35 +++
 rtl/shifter.sv | 19 +
 rtl/shift_sched.sv | 134 +++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shared-shifter scheduler.
//   shift_op_t    : requested operation (rotate-left, logical left,
//                   logical right, arithmetic right).
//   sched_state_t : scheduler FSM state; the 2'b11 encoding is unused.
//   SHIFT_W/AW    : datapath width and shift-amount width.
package shift_pkg;

  localparam int SHIFT_W  = 32;
  localparam int SHIFT_AW = 5;

  typedef enum logic [1:0] {
    ROL = 2'd0,
    SHL = 2'd1,
    SHR = 2'd2,
    SAR = 2'd3
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/shift_mask.sv
// Turns a rotate-left into ROL/SHL/SHR/SAR.
// result = (rotated & and_mask) | or_fill
//   op       : requested operation
//   amt      : shift amount 0..31
//   sign     : bit 31 of the original operand (SAR fill)
//   and_mask : bits of the rotated value to keep
//   or_fill  : bits forced to one (sign extension)
module shift_mask
  import shift_pkg::*;
(
  input  shift_op_t                 op,
  input  logic [SHIFT_AW-1:0]       amt,
  input  logic                      sign,
  output logic [SHIFT_W-1:0]        and_mask,
  output logic [SHIFT_W-1:0]        or_fill
);

  localparam logic [SHIFT_W-1:0] ONES = '1;

  always_comb begin
    and_mask = ONES;
    or_fill  = '0;
    case (op)
      ROL: and_mask = ONES;
      SHL: and_mask = ONES << amt;
      SHR: and_mask = ONES >> amt;
      SAR: begin
        and_mask = ONES >> amt;
        or_fill  = sign ? ~(ONES >> amt) : '0;
      end
      default: and_mask = ONES;
    endcase
  end

endmodule

// File: rtl/shifter.sv
// 32-bit rotate-left.
//   IN   : operand
//   SHFT : rotate amount 0..31
//   OUT  : IN rotated left by SHFT
module shifter (
  input  logic [31:0] IN,
  input  logic [4:0]  SHFT,
  output logic [31:0] OUT
);

  logic [63:0] dbl;

  // The upper half of the doubled word shifted left is the rotation.
  always_comb begin
    dbl = {IN, IN} << SHFT;
    OUT = dbl[63:32];
  end

endmodule

// File: rtl/shift_sched.sv
// Shared-shifter scheduler: two requesters (ALU, memory alignment) share one
// rotate-left shifter. One operation is in flight at a time:
// IDLE (grant) -> SHIFT (compute, register) -> DONE (hold result).
//
// Handshakes: a transfer happens on a rising CLK edge where VALID and READY
// are both high. A producer holds VALID and its payload stable until that
// edge; READY may depend combinationally on VALID, VALID never on READY.
//
// Ports:
//   CLK, RST              : clock, asynchronous active-high reset
//   REQ_VALID/REQ_READY   : per-requester request handshake (bit i = req i)
//   REQ_OPx/DATAx/AMTx    : per-requester operation, operand, amount
//   RES_VALID/RES_READY   : result handshake
//   RES_DATA, RES_ID      : result and the requester that owns it
//   BUSY                  : any state other than IDLE
//   DBG_STATE             : current FSM state
module shift_sched
  import shift_pkg::*;
#(
  parameter int W  = SHIFT_W,
  parameter int AW = SHIFT_AW
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [1:0]   REQ_VALID,
  output logic [1:0]   REQ_READY,
  input  logic [1:0]   REQ_OP0,
  input  logic [1:0]   REQ_OP1,
  input  logic [W-1:0] REQ_DATA0,
  input  logic [W-1:0] REQ_DATA1,
  input  logic [AW-1:0] REQ_AMT0,
  input  logic [AW-1:0] REQ_AMT1,
  output logic         RES_VALID,
  input  logic         RES_READY,
  output logic [W-1:0] RES_DATA,
  output logic         RES_ID,
  output logic         BUSY,
  output sched_state_t DBG_STATE
);

  sched_state_t   state, state_next;
  logic           ptr;          // requester favoured on contention
  logic [1:0]     grant;

  shift_op_t      op_q;
  logic [W-1:0]   data_q;
  logic [AW-1:0]  amt_q;
  logic           id_q;
  logic [W-1:0]   res_data_q;
  logic           res_id_q;

  logic [AW-1:0]  shft;
  logic [W-1:0]   rot;
  logic [W-1:0]   and_mask;
  logic [W-1:0]   or_fill;

  // Right shifts rotate left by (32-n) mod 32; the mask then clears the
  // bits that wrapped around.
  always_comb begin
    if (op_q == ROL || op_q == SHL) shft = amt_q;
    else                            shft = AW'(0) - amt_q;
  end

  shifter u_shifter (
    .IN   (data_q),
    .SHFT (shft),
    .OUT  (rot)
  );

  shift_mask u_mask (
    .op       (op_q),
    .amt      (amt_q),
    .sign     (data_q[W-1]),
    .and_mask (and_mask),
    .or_fill  (or_fill)
  );

  // Grant is gated by RST so REQ_READY drops the instant reset asserts.
  always_comb begin
    grant      = 2'b00;
    state_next = state;
    case (state)
      IDLE: begin
        if (!RST) begin
          case (REQ_VALID)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
          endcase
        end
        if (grant != 2'b00) state_next = SHIFT;
      end
      SHIFT: state_next = DONE;
      DONE:  if (RES_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      op_q       <= ROL;
      data_q     <= '0;
      amt_q      <= '0;
      id_q       <= 1'b0;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (grant != 2'b00) begin
        // Pointer moves only on an accept, to the requester not served.
        ptr    <= ~grant[1];
        id_q   <= grant[1];
        op_q   <= grant[1] ? shift_op_t'(REQ_OP1) : shift_op_t'(REQ_OP0);
        data_q <= grant[1] ? REQ_DATA1 : REQ_DATA0;
        amt_q  <= grant[1] ? REQ_AMT1  : REQ_AMT0;
      end
      if (state == SHIFT) begin
        res_data_q <= (rot & and_mask) | or_fill;
        res_id_q   <= id_q;
      end
    end
  end

  assign REQ_READY = grant;
  assign RES_VALID = (state == DONE);
  assign RES_DATA  = res_data_q;
  assign RES_ID    = res_id_q;
  assign BUSY      = (state != IDLE);
  assign DBG_STATE = state;

endmodule
